// File: rtl/sa_skew_feeder.sv
// Diagonal-skew operand feeder for an N x N int8 systolic PE array.
// Each start latches the run parameters, pulses the PE accumulator clear,
// streams K rows out of the A/B operand buffers and then waits for the
// wavefront to leave the array. Lane i is delayed i cycles, so PE(i,j)
// sees A[k][i] and B[k][j] in the same cycle.
module sa_skew_feeder #(
  parameter int N      = 4,
  parameter int ADDR_W = 12,
  parameter int K_W    = 16,
  parameter int PE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [N*8-1:0]    a_data,
  input  logic [N*8-1:0]    b_data,
  output logic [N*8-1:0]    left_out,
  output logic [N*8-1:0]    up_out,
  output logic              pe_clr_n,
  output logic              busy,
  output logic              done
);

  // Cycles after the last address until the corner PE's answer is final:
  // skew of both edges through the array plus the PE pipeline.
  localparam int FLUSH_CYC = 2 * (N - 1) + PE_LAT + 1;
  localparam int FLUSH_W   = $clog2(FLUSH_CYC + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [K_W-1:0]      k_len_q;
  logic [ADDR_W-1:0]   base_a_q;
  logic [ADDR_W-1:0]   base_b_q;
  logic [ADDR_W-1:0]   a_addr_q;
  logic [ADDR_W-1:0]   b_addr_q;
  logic [K_W-1:0]      feed_cnt_q;
  logic [FLUSH_W-1:0]  flush_cnt_q;
  logic                pe_clr_n_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_vld_q;

  // Run sequencer: parameter capture, address generation, flush timing, registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      feed_cnt_q  <= '0;
      flush_cnt_q <= '0;
      pe_clr_n_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_len_q    <= k_len;
            base_a_q   <= base_a;
            base_b_q   <= base_b;
            pe_clr_n_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          pe_clr_n_q <= 1'b1;
          feed_cnt_q <= '0;
          if (k_len_q == '0) begin
            // Nothing to stream: accumulators are already clear, report at once.
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            a_addr_q <= base_a_q;
            b_addr_q <= base_b_q;
            state_q  <= S_FEED;
          end
        end
        S_FEED: begin
          if (feed_cnt_q == k_len_q - K_W'(1)) begin
            // Last row issued; addresses hold their final value from here on.
            flush_cnt_q <= '0;
            state_q     <= S_FLUSH;
          end else begin
            feed_cnt_q <= feed_cnt_q + K_W'(1);
            a_addr_q   <= a_addr_q + ADDR_W'(1);
            b_addr_q   <= b_addr_q + ADDR_W'(1);
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here: one IDLE cycle between runs.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Read-data qualifier: buffer data is valid the cycle after an address is issued in FEED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= (state_q == S_FEED);
    end
  end

  assign a_addr   = a_addr_q;
  assign b_addr   = b_addr_q;
  assign pe_clr_n = pe_clr_n_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Per-lane pipeline: stage 0 is the output register, stages 1..gi form the diagonal skew.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [7:0] a_lane_d;
    logic [7:0] b_lane_d;
    logic [7:0] a_pipe_q [0:gi];
    logic [7:0] b_pipe_q [0:gi];

    // Empty slots carry zero so idle PEs accumulate nothing.
    assign a_lane_d = rd_vld_q ? a_data[8*gi +: 8] : 8'h00;
    assign b_lane_d = rd_vld_q ? b_data[8*gi +: 8] : 8'h00;

    // Shift this lane's operands through its output and skew registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int d = 0; d <= gi; d++) begin
          a_pipe_q[d] <= 8'h00;
          b_pipe_q[d] <= 8'h00;
        end
      end else begin
        a_pipe_q[0] <= a_lane_d;
        b_pipe_q[0] <= b_lane_d;
        for (int d = 1; d <= gi; d++) begin
          a_pipe_q[d] <= a_pipe_q[d-1];
          b_pipe_q[d] <= b_pipe_q[d-1];
        end
      end
    end

    assign left_out[8*gi +: 8] = a_pipe_q[gi];
    assign up_out[8*gi +: 8]   = b_pipe_q[gi];
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: each launched run pushes its expected
// per-cycle outputs into a queue; a negedge monitor pops and compares them,
// flags done/clear pulses nobody expected, and runs a 4x4 PE array model
// (offset 128) on the lane outputs to check the answers at done.
module tb_sa_skew_feeder;

  localparam int N      = 4;
  localparam int ADDR_W = 12;
  localparam int K_W    = 16;
  localparam int PE_LAT = 4;

  localparam int K_BUSY  = 0;
  localparam int K_DONE  = 1;
  localparam int K_CLR   = 2;
  localparam int K_AADDR = 3;
  localparam int K_BADDR = 4;
  localparam int K_LEFT  = 5;
  localparam int K_UP    = 6;

  typedef struct {
    int          cyc;
    int          kind;
    int          lane;
    logic [31:0] val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [K_W-1:0]    k_len;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [N*8-1:0]    a_data;
  logic [N*8-1:0]    b_data;
  logic [N*8-1:0]    left_out;
  logic [N*8-1:0]    up_out;
  logic              pe_clr_n;
  logic              busy;
  logic              done;

  logic [31:0] a_mem [0:4095];
  logic [31:0] b_mem [0:4095];

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  byte  hist_l [0:4095][0:N-1];
  byte  hist_u [0:4095][0:N-1];
  int   acc     [0:N-1][0:N-1];
  int   exp_acc [0:N-1][0:N-1];
  int   clr_cyc = 0;

  sa_skew_feeder #(.N(N), .ADDR_W(ADDR_W), .K_W(K_W), .PE_LAT(PE_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .base_a   (base_a),
    .base_b   (base_b),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .a_data   (a_data),
    .b_data   (b_data),
    .left_out (left_out),
    .up_out   (up_out),
    .pe_clr_n (pe_clr_n),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand buffers: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
  end

  task automatic chk(input string name, input int c, input int lane,
                     input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d lane=%0d got=%h want=%h", name, c, lane, got, want);
    end
  endtask

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  function automatic logic [31:0] actual(input int kind, input int lane);
    case (kind)
      K_BUSY:  return {31'd0, busy};
      K_DONE:  return {31'd0, done};
      K_CLR:   return {31'd0, pe_clr_n};
      K_AADDR: return {20'd0, a_addr};
      K_BADDR: return {20'd0, b_addr};
      K_LEFT:  return {24'd0, left_out[8*lane +: 8]};
      default: return {24'd0, up_out[8*lane +: 8]};
    endcase
  endfunction

  function automatic string kind_name(input int kind);
    case (kind)
      K_BUSY:  return "busy";
      K_DONE:  return "done";
      K_CLR:   return "pe_clr_n";
      K_AADDR: return "a_addr";
      K_BADDR: return "b_addr";
      K_LEFT:  return "left_out";
      default: return "up_out";
    endcase
  endfunction

  task automatic push(input int c, input int kind, input int lane, input logic [31:0] v);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.lane = lane;
    e.val  = v;
    q.push_back(e);
  endtask

  // Expected behaviour of one run whose start is sampled at the end of cycle t0.
  task automatic push_run(input int t0, input int kl, input int ba, input int bb, output int td);
    int k;
    td = (kl == 0) ? t0 + 2 : t0 + kl + 13;
    for (int t = t0 + 1; t <= td + 1; t++) begin
      push(t, K_BUSY, 0, (t <= td) ? 32'd1 : 32'd0);
      push(t, K_DONE, 0, (t == td) ? 32'd1 : 32'd0);
      push(t, K_CLR,  0, (t == t0 + 1) ? 32'd0 : 32'd1);
      if (kl > 0 && t >= t0 + 2 && t <= td) begin
        k = t - t0 - 2;
        if (k > kl - 1) k = kl - 1;
        push(t, K_AADDR, 0, 32'((ba + k) & 12'hFFF));
        push(t, K_BADDR, 0, 32'((bb + k) & 12'hFFF));
      end
      for (int i = 0; i < N; i++) begin
        k = t - t0 - 4 - i;
        if (k >= 0 && k < kl) begin
          push(t, K_LEFT, i, {24'd0, lane_byte(a_mem[(ba + k) & 4095], i)});
          push(t, K_UP,   i, {24'd0, lane_byte(b_mem[(bb + k) & 4095], i)});
        end else begin
          push(t, K_LEFT, i, 32'd0);
          push(t, K_UP,   i, 32'd0);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < kl; kk++) begin
          s += (int'(byte'(lane_byte(a_mem[(ba + kk) & 4095], i))) + 128) *
               int'(byte'(lane_byte(b_mem[(bb + kk) & 4095], j)));
        end
        exp_acc[i][j] = s;
      end
    end
  endtask

  // Monitor: PE model update, scoreboard pops, unexpected pulse detection.
  always @(negedge clk) begin
    int   ta;
    bit   exp_done_now;
    bit   exp_clr_now;
    bit   check_pe;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      hist_l[cyc & 4095][i] = left_out[8*i +: 8];
      hist_u[cyc & 4095][i] = up_out[8*i +: 8];
    end
    if (pe_clr_n === 1'b0) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] = 0;
      clr_cyc = cyc;
    end else begin
      ta = cyc - PE_LAT;
      if (ta > clr_cyc && ta >= 8) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] += (int'(hist_l[(ta - j) & 4095][i]) + 128) *
                         int'(hist_u[(ta - i) & 4095][j]);
      end
    end
    exp_done_now = 1'b0;
    exp_clr_now  = 1'b0;
    check_pe     = 1'b0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL stale_%s cyc=%0d got=missed want=cyc%0d", kind_name(e.kind), cyc, e.cyc);
      end else begin
        chk(kind_name(e.kind), cyc, e.lane, actual(e.kind, e.lane), e.val);
        if (e.kind == K_DONE) begin
          exp_done_now = 1'b1;
          if (e.val == 32'd1) check_pe = 1'b1;
        end
        if (e.kind == K_CLR) exp_clr_now = 1'b1;
      end
    end
    if (done === 1'b1 && !exp_done_now) begin
      n_fail++;
      $display("FAIL unexpected_done cyc=%0d got=1 want=0", cyc);
    end
    if (pe_clr_n === 1'b0 && !exp_clr_now) begin
      n_fail++;
      $display("FAIL unexpected_clr cyc=%0d got=0 want=1", cyc);
    end
    if (check_pe) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          chk($sformatf("pe_answer_%0d_%0d", i, j), cyc, i, acc[i][j], exp_acc[i][j]);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Launch one run from a negedge in IDLE and wait until it is back in IDLE.
  task automatic run_one(input int kl, input int ba, input int bb);
    int t0;
    int td;
    start  = 1'b1;
    k_len  = K_W'(kl);
    base_a = ADDR_W'(ba);
    base_b = ADDR_W'(bb);
    t0 = cyc;
    push_run(t0, kl, ba, bb, td);
    $display("run start cyc=%0d k_len=%0d base_a=%h base_b=%h done_expected=%0d", t0, kl, ba, bb, td);
    @(negedge clk);
    start = 1'b0;
    wait_cyc(td + 1);
  endtask

  initial begin
    int td;
    rst    = 1'b1;
    start  = 1'b0;
    k_len  = '0;
    base_a = '0;
    base_b = '0;
    for (int a = 0; a < 4096; a++) begin
      a_mem[a] = $urandom;
      b_mem[a] = $urandom;
    end
    // Hand-picked rows for the basic run.
    a_mem[0] = 32'h04030201; a_mem[1] = 32'h14131211; a_mem[2] = 32'h24232221;
    b_mem[0] = 32'hF4F3F2F1; b_mem[1] = 32'h7F80FF01; b_mem[2] = 32'h00000080;

    #1 rst = 1'b0;
    #2;
    chk("rst_a_addr",   cyc, 0, {20'd0, a_addr}, 32'd0);
    chk("rst_b_addr",   cyc, 0, {20'd0, b_addr}, 32'd0);
    chk("rst_left_out", cyc, 0, left_out, 32'd0);
    chk("rst_up_out",   cyc, 0, up_out, 32'd0);
    chk("rst_pe_clr_n", cyc, 0, {31'd0, pe_clr_n}, 32'd1);
    chk("rst_busy",     cyc, 0, {31'd0, busy}, 32'd0);
    chk("rst_done",     cyc, 0, {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_one(3, 12'h000, 12'h000);
    run_one(0, 12'h005, 12'h009);
    run_one(4, 12'hFFE, 12'h7FF);
    run_one(8, 12'h100, 12'h200);

    // start held high: three back-to-back runs, parameters changed mid-run.
    start  = 1'b1;
    k_len  = 16'd2;
    base_a = 12'h010;
    base_b = 12'h020;
    push_run(cyc, 2, 12'h010, 12'h020, td);
    $display("held run 1 start cyc=%0d done_expected=%0d", cyc, td);
    repeat (3) @(negedge clk);
    k_len  = 16'd5;
    base_a = 12'h030;
    base_b = 12'h040;
    wait_cyc(td + 1);
    push_run(cyc, 5, 12'h030, 12'h040, td);
    $display("held run 2 start cyc=%0d done_expected=%0d", cyc, td);
    repeat (3) @(negedge clk);
    k_len  = 16'd1;
    base_a = 12'h050;
    base_b = 12'h060;
    wait_cyc(td + 1);
    push_run(cyc, 1, 12'h050, 12'h060, td);
    $display("held run 3 start cyc=%0d done_expected=%0d", cyc, td);
    @(negedge clk);
    start = 1'b0;
    wait_cyc(td + 1);

    // Asynchronous reset in the middle of FEED aborts the run.
    for (int k = 0; k < 8; k++) begin
      a_mem[12'h300 + k] = 32'h5A5A5A5A;
      b_mem[12'h400 + k] = 32'hA5A5A5A5;
    end
    start  = 1'b1;
    k_len  = 16'd8;
    base_a = 12'h300;
    base_b = 12'h400;
    push_run(cyc, 8, 12'h300, 12'h400, td);
    $display("abort run start cyc=%0d", cyc);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    chk("abort_left_out", cyc, 0, left_out, 32'd0);
    chk("abort_up_out",   cyc, 0, up_out, 32'd0);
    chk("abort_busy",     cyc, 0, {31'd0, busy}, 32'd0);
    chk("abort_pe_clr_n", cyc, 0, {31'd0, pe_clr_n}, 32'd1);
    chk("abort_done",     cyc, 0, {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_abort_busy", cyc, 0, {31'd0, busy}, 32'd0);
    chk("post_abort_left", cyc, 0, left_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
